mem_port_arbiter: RTL and testbench

- Shares one unified, multi-cycle memory port between the Fetch stage (instruction reads) and the Memory stage (loads/stores). It replaces the separate Imem/Dmem ports at the Top level.
- One transaction is outstanding at a time. D-side has priority, with a starvation guard that protects fetch.
- A fetch-redirect flush suppresses stale instruction responses.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states and the
// latched bus request that drives the mem* outputs.
package mem_port_arbiter_pkg;

    localparam int PKG_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = 4;
    localparam int STARVE_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbiterState_;

    typedef struct packed {
        logic [PKG_DATA_WIDTH-1:0] address;
        logic [PKG_DATA_WIDTH-1:0] writeData;
        logic [BE_WIDTH-1:0]       byteEnable;
        logic                      write;
    } memRequest_;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and the
// memory stage; D-side priority with a starvation guard, fetch flush drops.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_WIDTH   = PKG_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instructionRequest,
    input  logic [DATA_WIDTH-1:0] instructionAddress,
    input  logic                  fetchFlush,
    output logic [DATA_WIDTH-1:0] instructionData,
    output logic                  instructionDataValid,
    input  logic                  dataRequest,
    input  logic                  dataWrite,
    input  logic [DATA_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] storeData,
    input  logic [BE_WIDTH-1:0]   byteEnable,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic                  loadDataValid,
    output logic                  storeComplete,
    output logic                  memRequest,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic [BE_WIDTH-1:0]   memByteEnable,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam logic [STARVE_WIDTH-1:0] LIMIT = STARVE_WIDTH'(STARVE_LIMIT);

    arbiterState_            state_q, state_d;
    memRequest_              req_q, req_d;
    logic [STARVE_WIDTH-1:0] starve_q, starve_d;
    logic                    drop_q, drop_d;
    logic                    mem_request_q, mem_request_d;
    logic [DATA_WIDTH-1:0]   instr_data_q, instr_data_d;
    logic                    instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    store_done_q, store_done_d;

    logic fetch_ok;
    logic force_fetch;

    // A flushed fetch cannot be granted, so it cannot claim the starvation slot either.
    assign fetch_ok    = instructionRequest && !fetchFlush;
    assign force_fetch = fetch_ok && (starve_q == LIMIT);

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        starve_d      = starve_q;
        drop_d        = drop_q;
        mem_request_d = mem_request_q;
        instr_data_d  = instr_data_q;
        instr_valid_d = 1'b0;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        store_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dataRequest && !force_fetch) begin
                    state_d          = BUSY_D;
                    mem_request_d    = 1'b1;
                    req_d.address    = dataAddress;
                    req_d.writeData  = dataWrite ? storeData : '0;
                    req_d.byteEnable = dataWrite ? byteEnable : '1;
                    req_d.write      = dataWrite;
                    if (!instructionRequest)
                        starve_d = '0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + STARVE_WIDTH'(1);
                end else if (fetch_ok) begin
                    state_d          = BUSY_I;
                    mem_request_d    = 1'b1;
                    req_d.address    = instructionAddress;
                    req_d.writeData  = '0;
                    req_d.byteEnable = '1;
                    req_d.write      = 1'b0;
                    starve_d         = '0;
                end
            end
            BUSY_I: begin
                if (memAck) begin
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                    drop_d        = 1'b0;
                    // A flush coincident with the ack still squashes the response.
                    if (!(drop_q || fetchFlush)) begin
                        instr_valid_d = 1'b1;
                        instr_data_d  = memReadData;
                    end
                end else if (fetchFlush) begin
                    drop_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (memAck) begin
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                    if (req_q.write) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b1;
                        load_data_d  = memReadData;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            starve_q      <= '0;
            drop_q        <= 1'b0;
            mem_request_q <= 1'b0;
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
            load_data_q   <= '0;
            load_valid_q  <= 1'b0;
            store_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            starve_q      <= starve_d;
            drop_q        <= drop_d;
            mem_request_q <= mem_request_d;
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            store_done_q  <= store_done_d;
        end
    end

    assign instructionData      = instr_data_q;
    assign instructionDataValid = instr_valid_q;
    assign loadData             = load_data_q;
    assign loadDataValid        = load_valid_q;
    assign storeComplete        = store_done_q;
    assign memRequest           = mem_request_q;
    assign memWrite             = req_q.write;
    assign memAddress           = req_q.address;
    assign memWriteData         = req_q.writeData;
    assign memByteEnable        = req_q.byteEnable;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan scenarios followed by a randomized run, all compared
// cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instructionRequest = 1'b0;
    logic [31:0] instructionAddress = '0;
    logic        fetchFlush = 1'b0;
    logic [31:0] instructionData;
    logic        instructionDataValid;
    logic        dataRequest = 1'b0;
    logic        dataWrite = 1'b0;
    logic [31:0] dataAddress = '0;
    logic [31:0] storeData = '0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;
    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memAck = 1'b0;
    logic [31:0] memReadData = '0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .instructionRequest(instructionRequest), .instructionAddress(instructionAddress),
        .fetchFlush(fetchFlush), .instructionData(instructionData),
        .instructionDataValid(instructionDataValid),
        .dataRequest(dataRequest), .dataWrite(dataWrite), .dataAddress(dataAddress),
        .storeData(storeData), .byteEnable(byteEnable), .loadData(loadData),
        .loadDataValid(loadDataValid), .storeComplete(storeComplete),
        .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memByteEnable(memByteEnable),
        .memAck(memAck), .memReadData(memReadData)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), the
    // transaction on the bus, and the responses expected after each edge.
    int          m_owner = 0;
    int          m_starve = 0;
    bit          m_drop = 0;
    bit          m_req = 0, m_wr = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    bit          m_ivld = 0, m_lvld = 0, m_sc = 0;
    logic [31:0] m_idata = '0, m_ldata = '0;
    bit          fetch_ok;

    always @(posedge clock) begin
        m_ivld = 0; m_lvld = 0; m_sc = 0;
        if (reset) begin
            m_owner = 0; m_starve = 0; m_drop = 0; m_req = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_idata = '0; m_ldata = '0;
        end else if (m_owner == 0) begin
            fetch_ok = instructionRequest && !fetchFlush;
            if (dataRequest && !(fetch_ok && m_starve == LIMIT)) begin
                m_owner = 2; m_req = 1; m_wr = dataWrite; m_addr = dataAddress;
                m_wdata = dataWrite ? storeData : 32'h0;
                m_be    = dataWrite ? byteEnable : 4'hF;
                m_starve = instructionRequest ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else if (fetch_ok) begin
                m_owner = 1; m_req = 1; m_wr = 0; m_addr = instructionAddress;
                m_wdata = 32'h0; m_be = 4'hF; m_starve = 0;
            end
        end else if (memAck) begin
            if (m_owner == 1 && !(m_drop || fetchFlush)) begin
                m_ivld = 1; m_idata = memReadData;
            end
            if (m_owner == 2) begin
                if (m_wr) m_sc = 1;
                else begin m_lvld = 1; m_ldata = memReadData; end
            end
            m_owner = 0; m_req = 0; m_drop = 0;
        end else if (m_owner == 1 && fetchFlush) begin
            m_drop = 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("memRequest",    32'(memRequest),           32'(m_req));
        chk("memWrite",      32'(memWrite),             32'(m_wr));
        chk("memAddress",    memAddress,                m_addr);
        chk("memWriteData",  memWriteData,              m_wdata);
        chk("memByteEnable", 32'(memByteEnable),        32'(m_be));
        chk("iValid",        32'(instructionDataValid), 32'(m_ivld));
        chk("iData",         instructionData,           m_idata);
        chk("lValid",        32'(loadDataValid),        32'(m_lvld));
        chk("lData",         loadData,                  m_ldata);
        chk("storeDone",     32'(storeComplete),        32'(m_sc));
    endtask

    bit auto_mem = 0;
    int ack_pct = 100;
    int spur_pct = 0;

    // Advance one edge, compare, then let the memory model respond.
    task automatic tick();
        @(posedge clock);
        #2;
        check_all();
        if (auto_mem) begin
            if (memRequest && !memAck)
                memAck = ($urandom_range(0, 99) < ack_pct);
            else
                memAck = !memRequest && ($urandom_range(0, 99) < spur_pct);
            memReadData = $urandom;
        end
    endtask

    task automatic idle_inputs();
        instructionRequest = 0; fetchFlush = 0; dataRequest = 0; dataWrite = 0;
        memAck = 0;
    endtask

    int seq[$];
    int exp_seq[7] = '{1, 1, 1, 1, 0, 1, 1};
    int store_cnt;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_memRequest", 32'(memRequest), 32'h0);
        chk("rst_iValid", 32'(instructionDataValid), 32'h0);
        reset = 0;
        tick();

        // Lone fetch
        instructionRequest = 1; instructionAddress = 32'h100;
        tick();
        chk("fetch_issue_addr", memAddress, 32'h100);
        memAck = 1; memReadData = 32'h00500093;
        tick();
        chk("fetch_valid", 32'(instructionDataValid), 32'h1);
        chk("fetch_data", instructionData, 32'h00500093);
        idle_inputs();
        tick();
        chk("fetch_pulse_once", 32'(instructionDataValid), 32'h0);

        // Simultaneous I and D: D first, then I on the following IDLE cycle
        instructionRequest = 1; instructionAddress = 32'h104;
        dataRequest = 1; dataWrite = 0; dataAddress = 32'h2000;
        tick();
        chk("sim_d_first", memAddress, 32'h2000);
        memAck = 1; memReadData = 32'hDEADBEEF;
        tick();
        chk("sim_load_valid", 32'(loadDataValid), 32'h1);
        chk("sim_load_data", loadData, 32'hDEADBEEF);
        dataRequest = 0; memAck = 0;
        tick();
        chk("sim_i_next", memAddress, 32'h104);
        memAck = 1; memReadData = 32'h11112222;
        tick();
        chk("sim_i_valid", 32'(instructionDataValid), 32'h1);
        idle_inputs();
        tick();

        // Starvation guard: six stores against a waiting fetch
        auto_mem = 1; ack_pct = 100; spur_pct = 0;
        instructionRequest = 1; instructionAddress = 32'h300;
        dataRequest = 1; dataWrite = 1; dataAddress = 32'h5000;
        storeData = 32'hCAFE0000; byteEnable = 4'hF;
        store_cnt = 0;
        for (int c = 0; c < 60 && (store_cnt < 6 || instructionRequest); c++) begin
            tick();
            if (storeComplete) begin
                seq.push_back(1); store_cnt++;
                dataAddress = 32'h5000 + 32'(4 * store_cnt);
                if (store_cnt == 6) dataRequest = 0;
            end
            if (instructionDataValid) begin
                seq.push_back(0); instructionRequest = 0;
            end
        end
        chk("starve_len", 32'(seq.size()), 32'd7);
        for (int i = 0; i < 7 && i < seq.size(); i++)
            chk("starve_order", 32'(seq[i]), 32'(exp_seq[i]));
        auto_mem = 0;
        idle_inputs();
        tick();

        // Flush while BUSY_I drops the response
        instructionRequest = 1; instructionAddress = 32'h180;
        tick();
        instructionRequest = 0; fetchFlush = 1;
        tick();
        fetchFlush = 0; memAck = 1; memReadData = 32'hBAD0BAD0;
        tick();
        chk("flush_dropped", 32'(instructionDataValid), 32'h0);
        chk("flush_idle", 32'(memRequest), 32'h0);
        memAck = 0;
        tick();
        instructionRequest = 1; instructionAddress = 32'h200;
        tick();
        chk("refetch_addr", memAddress, 32'h200);
        memAck = 1; memReadData = 32'h12345678;
        tick();
        chk("refetch_valid", 32'(instructionDataValid), 32'h1);
        chk("refetch_data", instructionData, 32'h12345678);
        idle_inputs();
        tick();

        // Store lanes held stable while inputs wander
        dataRequest = 1; dataWrite = 1; dataAddress = 32'h3004;
        storeData = 32'h000000AB; byteEnable = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            dataAddress = $urandom; storeData = $urandom; byteEnable = 4'($urandom);
            dataWrite = 1'($urandom);
            tick();
            chk("lane_be", 32'(memByteEnable), 32'h1);
            chk("lane_wr", 32'(memWrite), 32'h1);
            chk("lane_addr", memAddress, 32'h3004);
            chk("lane_data", memWriteData, 32'hAB);
        end
        dataRequest = 0; memAck = 1;
        tick();
        chk("lane_done", 32'(storeComplete), 32'h1);
        chk("lane_no_load", 32'(loadDataValid), 32'h0);
        idle_inputs();
        tick();

        // Reset in BUSY_D, then a late ack
        instructionRequest = 1; instructionAddress = 32'h400;
        dataRequest = 1; dataWrite = 0; dataAddress = 32'h4000;
        tick();
        chk("rb_busy", 32'(memRequest), 32'h1);
        reset = 1; dataRequest = 0; instructionRequest = 0;
        tick();
        chk("rb_req_low", 32'(memRequest), 32'h0);
        reset = 0; memAck = 1; memReadData = 32'h55AA55AA;
        tick();
        chk("rb_no_load", 32'(loadDataValid), 32'h0);
        chk("rb_no_fetch", 32'(instructionDataValid), 32'h0);
        chk("rb_starve", 32'(dut.starve_q), 32'h0);
        chk("rb_state", 32'(dut.state_q), 32'(IDLE));
        memAck = 0;
        tick();

        // Randomized traffic
        auto_mem = 1; ack_pct = 40; spur_pct = 10;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset              = ($urandom_range(0, 99) == 0);
            instructionRequest = ($urandom_range(0, 99) < 60);
            fetchFlush         = ($urandom_range(0, 99) < 8);
            dataRequest        = ($urandom_range(0, 99) < 50);
            dataWrite          = 1'($urandom);
            instructionAddress = $urandom;
            dataAddress        = $urandom;
            storeData          = $urandom;
            byteEnable         = 4'($urandom);
        end
        reset = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
